// File: rtl/spi_pkg.sv
// Shared SPI target definitions: default word width, synchronizer depth and FSM state type.
`timescale 1ns/1ps
package spi_pkg;

   localparam int SPI_WIDTH       = 8;
   localparam int SPI_SYNC_STAGES = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer for pins asynchronous to clk.
// RESET_VAL selects the idle level the chain settles to under reset.
`timescale 1ns/1ps
module sync_ff #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= {STAGES{RESET_VAL}};
      end else begin
         sync_reg <= {sync_reg[STAGES-2:0], d};
      end
   end

   assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 responder. All SPI pins are oversampled in the clk domain; responds
// with host-supplied tx_data or an echo of the last received word.
`timescale 1ns/1ps
module spi_target
   import spi_pkg::*;
#(
   parameter int WIDTH       = SPI_WIDTH,
   parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             spi_sclk,
   input  logic             spi_mosi,
   input  logic             spi_ss_n,
   output logic             spi_miso,
   output logic             spi_miso_oe,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_taken,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             frame_err,
   output logic             busy
);

   localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic sclk_s, mosi_s, ss_n_s;

   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .d(spi_sclk), .q(sclk_s)
   );
   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s)
   );
   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss_n (
      .clk(clk), .rst_n(rst_n), .d(spi_ss_n), .q(ss_n_s)
   );

   spi_state_e       state_reg;
   logic             sclk_d_reg;
   logic             ss_n_d_reg;
   logic [WIDTH-1:0] rx_shift_reg;
   logic [WIDTH-1:0] tx_shift_reg;
   logic [WIDTH-1:0] rx_data_reg;
   logic [WIDTH-1:0] last_rx_reg;
   logic [CNT_W-1:0] bit_cnt_reg;
   logic             load_pending_reg;
   logic             tx_taken_reg;
   logic             rx_valid_reg;
   logic             frame_err_reg;

   logic             sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic [WIDTH-1:0] rx_word_next;
   logic [WIDTH-1:0] tx_load_word;
   logic             drive_active;

   assign sclk_rise    = sclk_s & ~sclk_d_reg;
   assign sclk_fall    = ~sclk_s & sclk_d_reg;
   assign ss_rise      = ss_n_s & ~ss_n_d_reg;
   assign ss_fall      = ~ss_n_s & ss_n_d_reg;
   assign rx_word_next = {rx_shift_reg[WIDTH-2:0], mosi_s};
   assign tx_load_word = tx_valid ? tx_data : last_rx_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= IDLE;
         sclk_d_reg       <= 1'b0;
         ss_n_d_reg       <= 1'b1;
         rx_shift_reg     <= '0;
         tx_shift_reg     <= '0;
         rx_data_reg      <= '0;
         last_rx_reg      <= '0;
         bit_cnt_reg      <= '0;
         load_pending_reg <= 1'b0;
         tx_taken_reg     <= 1'b0;
         rx_valid_reg     <= 1'b0;
         frame_err_reg    <= 1'b0;
      end else begin
         sclk_d_reg    <= sclk_s;
         ss_n_d_reg    <= ss_n_s;
         tx_taken_reg  <= 1'b0;
         rx_valid_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               // sclk/mosi activity is ignored until select falls
               if (ss_fall) begin
                  state_reg        <= ACTIVE;
                  tx_shift_reg     <= tx_load_word;
                  tx_taken_reg     <= tx_valid;
                  rx_shift_reg     <= '0;
                  bit_cnt_reg      <= '0;
                  load_pending_reg <= 1'b0;
               end
            end
            ACTIVE: begin
               // Deselect takes priority over any sclk edge in the same cycle
               if (ss_rise) begin
                  state_reg        <= IDLE;
                  frame_err_reg    <= (bit_cnt_reg != '0);
                  bit_cnt_reg      <= '0;
                  load_pending_reg <= 1'b0;
               end else if (sclk_rise) begin
                  rx_shift_reg <= rx_word_next;
                  if (bit_cnt_reg == LAST_BIT) begin
                     bit_cnt_reg      <= '0;
                     rx_data_reg      <= rx_word_next;
                     last_rx_reg      <= rx_word_next;
                     rx_valid_reg     <= 1'b1;
                     load_pending_reg <= 1'b1;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                  end
               end else if (sclk_fall) begin
                  // The falling edge after a completed word reloads instead of shifting
                  if (load_pending_reg) begin
                     tx_shift_reg     <= tx_load_word;
                     tx_taken_reg     <= tx_valid;
                     load_pending_reg <= 1'b0;
                  end else begin
                     tx_shift_reg <= {tx_shift_reg[WIDTH-2:0], 1'b0};
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Pad is released in the same cycle the deselect edge is seen
   assign drive_active = (state_reg == ACTIVE) && !ss_rise;
   assign spi_miso     = drive_active & tx_shift_reg[WIDTH-1];
   assign spi_miso_oe  = drive_active;
   assign busy         = (state_reg == ACTIVE);
   assign tx_taken     = tx_taken_reg;
   assign rx_data      = rx_data_reg;
   assign rx_valid     = rx_valid_reg;
   assign frame_err    = frame_err_reg;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: drives an SPI mode-0 initiator and
// scoreboards received words against a queue of expected values.
`timescale 1ns/1ps
module tb_spi_target;
   import spi_pkg::*;

   localparam int W  = 8;
   localparam int SS = 2;

   logic         clk      = 1'b0;
   logic         rst_n    = 1'b0;
   logic         spi_sclk = 1'b0;
   logic         spi_mosi = 1'b0;
   logic         spi_ss_n = 1'b1;
   logic [W-1:0] tx_data  = '0;
   logic         tx_valid = 1'b0;
   logic         spi_miso, spi_miso_oe, tx_taken, rx_valid, frame_err, busy;
   logic [W-1:0] rx_data;

   int tests_run     = 0;
   int tests_failed  = 0;
   int rx_valid_cnt  = 0;
   int tx_taken_cnt  = 0;
   int frame_err_cnt = 0;

   logic [W-1:0] exp_rx_q[$];
   logic [W-1:0] exp_word;

   always #20 clk = ~clk;

   spi_target #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst_n(rst_n),
      .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_taken(tx_taken),
      .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
   );

   // Scoreboard: every rx_valid pulse pops one expected word
   always @(negedge clk) begin
      if (rx_valid) begin
         rx_valid_cnt++;
         tests_run++;
         if (exp_rx_q.size() == 0) begin
            tests_failed++;
            $display("FAIL rx_unexpected: rx_data=%02h with no word expected", rx_data);
         end else begin
            exp_word = exp_rx_q.pop_front();
            if (rx_data !== exp_word) begin
               tests_failed++;
               $display("FAIL rx_word: got %02h expected %02h", rx_data, exp_word);
            end else begin
               $display("[TB] rx word %02h", rx_data);
            end
         end
      end
      if (tx_taken)  tx_taken_cnt++;
      if (frame_err) frame_err_cnt++;
   end

   task automatic spi_bits(input logic [15:0] mosi_bits, input int n, output logic [15:0] miso_bits);
      miso_bits = '0;
      for (int i = 0; i < n; i++) begin
         spi_mosi = mosi_bits[n-1-i];
         #100 spi_sclk = 1'b1;
         #99  miso_bits[n-1-i] = spi_miso;
         #1   spi_sclk = 1'b0;
      end
   endtask

   task automatic select_start();
      spi_ss_n = 1'b0;
      #300;
   endtask

   task automatic select_end();
      #200 spi_ss_n = 1'b1;
      #400;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({busy, spi_miso_oe, spi_miso, tx_taken, rx_valid, frame_err} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: outputs=%b expected 000000",
                  {busy, spi_miso_oe, spi_miso, tx_taken, rx_valid, frame_err});
      end
      tests_run++;
      if (rx_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_rx_data: got %02h expected 00", rx_data);
      end
      rst_n = 1'b1;
      #400;
      $display("[TB] reset checked");
   endtask

   task automatic test_echo();
      logic [15:0] m;
      int rxv0, txt0;
      rxv0 = rx_valid_cnt; txt0 = tx_taken_cnt;
      tx_valid = 1'b0;
      exp_rx_q.push_back(8'h12);
      select_start();
      spi_bits(16'h0012, 8, m);
      select_end();
      tests_run++;
      if (rx_valid_cnt - rxv0 !== 1 || rx_data !== 8'h12) begin
         tests_failed++;
         $display("FAIL echo_write: pulses=%0d rx_data=%02h expected 1 pulse of 12", rx_valid_cnt - rxv0, rx_data);
      end
      exp_rx_q.push_back(8'h12);
      select_start();
      spi_bits(16'h0012, 8, m);
      select_end();
      tests_run++;
      if (m[7:0] !== 8'h12) begin
         tests_failed++;
         $display("FAIL echo_read: miso=%02h expected 12", m[7:0]);
      end
      tests_run++;
      if (tx_taken_cnt != txt0) begin
         tests_failed++;
         $display("FAIL echo_tx_taken: pulses=%0d expected 0", tx_taken_cnt - txt0);
      end
      $display("[TB] echo read miso=%02h", m[7:0]);
   endtask

   task automatic test_abort();
      logic [15:0] m;
      int fe0, rxv0;
      fe0 = frame_err_cnt; rxv0 = rx_valid_cnt;
      select_start();
      spi_bits(16'h00FF, 5, m);
      #200 spi_ss_n = 1'b1;
      repeat (SS + 2) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (spi_miso_oe !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_oe: spi_miso_oe=%b expected 0 within %0d clk", spi_miso_oe, SS + 2);
      end
      #400;
      tests_run++;
      if (frame_err_cnt - fe0 !== 1) begin
         tests_failed++;
         $display("FAIL abort_frame_err: high cycles=%0d expected 1", frame_err_cnt - fe0);
      end
      tests_run++;
      if (rx_data !== 8'h12 || rx_valid_cnt != rxv0) begin
         tests_failed++;
         $display("FAIL abort_rx: rx_data=%02h pulses=%0d expected 12 and 0", rx_data, rx_valid_cnt - rxv0);
      end
      $display("[TB] aborted frame, frame_err cycles=%0d", frame_err_cnt - fe0);
   endtask

   task automatic test_host_response();
      logic [15:0] m;
      int txt0;
      txt0 = tx_taken_cnt;
      tx_data  = 8'hA5;
      tx_valid = 1'b1;
      exp_rx_q.push_back(8'h3C);
      select_start();
      tx_valid = 1'b0;
      spi_bits(16'h003C, 8, m);
      select_end();
      tests_run++;
      if (m[7:0] !== 8'hA5) begin
         tests_failed++;
         $display("FAIL host_miso: miso=%02h expected a5", m[7:0]);
      end
      tests_run++;
      if (tx_taken_cnt - txt0 !== 1) begin
         tests_failed++;
         $display("FAIL host_tx_taken: pulses=%0d expected 1", tx_taken_cnt - txt0);
      end
      tests_run++;
      if (rx_data !== 8'h3C) begin
         tests_failed++;
         $display("FAIL host_rx: rx_data=%02h expected 3c", rx_data);
      end
      $display("[TB] host response miso=%02h", m[7:0]);
   endtask

   task automatic test_back_to_back();
      logic [15:0] m;
      int rxv0;
      rxv0 = rx_valid_cnt;
      exp_rx_q.push_back(8'h81);
      exp_rx_q.push_back(8'h7E);
      select_start();
      spi_bits(16'h817E, 16, m);
      select_end();
      tests_run++;
      if (rx_valid_cnt - rxv0 !== 2) begin
         tests_failed++;
         $display("FAIL b2b_pulses: rx_valid pulses=%0d expected 2", rx_valid_cnt - rxv0);
      end
      tests_run++;
      if (m !== 16'h3C81) begin
         tests_failed++;
         $display("FAIL b2b_miso: miso=%04h expected 3c81", m);
      end
      $display("[TB] back-to-back miso=%04h", m);
   endtask

   task automatic test_idle_noise();
      int rxv0;
      logic busy_seen, oe_seen;
      rxv0 = rx_valid_cnt;
      busy_seen = 1'b0; oe_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         spi_mosi = 1'($urandom_range(0, 1));
         spi_sclk = ~spi_sclk;
         #100;
         busy_seen = busy_seen | busy;
         oe_seen   = oe_seen | spi_miso_oe;
      end
      #400;
      tests_run++;
      if (rx_valid_cnt != rxv0) begin
         tests_failed++;
         $display("FAIL idle_rx_valid: pulses=%0d expected 0", rx_valid_cnt - rxv0);
      end
      tests_run++;
      if (busy_seen !== 1'b0 || oe_seen !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_busy_oe: busy=%b oe=%b expected 0 0", busy_seen, oe_seen);
      end
      $display("[TB] idle noise ignored");
   endtask

   task automatic test_reset_mid();
      logic [15:0] m;
      int fe0;
      fe0 = frame_err_cnt;
      select_start();
      spi_bits(16'h00A0, 3, m);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({busy, spi_miso_oe, spi_miso, tx_taken, rx_valid, frame_err} !== 6'b0 || rx_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL midreset_outputs: ctrl=%b rx_data=%02h expected 000000 00",
                  {busy, spi_miso_oe, spi_miso, tx_taken, rx_valid, frame_err}, rx_data);
      end
      spi_ss_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #400;
      exp_rx_q.push_back(8'h55);
      select_start();
      spi_bits(16'h0055, 8, m);
      select_end();
      tests_run++;
      if (frame_err_cnt != fe0) begin
         tests_failed++;
         $display("FAIL midreset_frame_err: cycles=%0d expected 0", frame_err_cnt - fe0);
      end
      tests_run++;
      if (rx_data !== 8'h55 || m[7:0] !== 8'h00) begin
         tests_failed++;
         $display("FAIL midreset_xfer: rx_data=%02h miso=%02h expected 55 00", rx_data, m[7:0]);
      end
      $display("[TB] transfer after mid-frame reset rx=%02h", rx_data);
   endtask

   initial begin
      test_reset();
      test_echo();
      test_abort();
      test_host_response();
      test_back_to_back();
      test_idle_noise();
      test_reset_mid();
      tests_run++;
      if (exp_rx_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: %0d expected words never received", exp_rx_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI mode-0 responder (CPOL=0, CPHA=0) inside the VGA design.
- Receives bytes from an external SPI initiator on spi_sclk / spi_mosi / spi_ss_n.
- Shifts out a response byte on spi_miso: either host-supplied tx_data, or an echo of the last received byte.
- All SPI pins are asynchronous to clk. They are oversampled through synchronizers, and all logic runs in the clk domain.

Parameters:
- WIDTH, 8, bits per SPI word.
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer (minimum 2).

Ports:
- clk  in  1  system clock (25 MHz nominal); must run at least 4x the spi_sclk frequency.
- rst_n  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock from the initiator (maps to ui_in[1]).
- spi_mosi  in  1  initiator data in (ui_in[0]).
- spi_ss_n  in  1  active-low select (ui_in[2]).
- spi_miso  out  1  responder data out (uio_out[0]).
- spi_miso_oe  out  1  output enable for the spi_miso pad.
- tx_data  in  WIDTH  response word supplied by the host logic.
- tx_valid  in  1  tx_data is valid; sampled at each word load.
- tx_taken  out  1  1-cycle pulse when tx_data was loaded.
- rx_data  out  WIDTH  last complete received word.
- rx_valid  out  1  1-cycle pulse when rx_data updates.
- frame_err  out  1  1-cycle pulse when spi_ss_n deasserts mid-word.
- busy  out  1  synchronized select is active.

Behaviour:
- Reset (async, rst_n=0):
  - Synchronizer flops are set to idle (sclk=0, ss_n=1, mosi=0).
  - rx_shift, tx_shift, rx_data and bit_cnt are cleared to 0.
  - All pulse outputs, busy, spi_miso and spi_miso_oe are 0.
  - An echo register (last_rx) is cleared to 0.
- Synchronization: the edge detector compares synchronizer output stage N with a registered copy of it. An edge is therefore visible SYNC_STAGES+1 clk cycles after the pin changes.
- States: IDLE and ACTIVE.
- IDLE -> ACTIVE on the synced ss_n falling edge. In that same cycle, word load:
  - If tx_valid=1: tx_shift<=tx_data and tx_taken pulses.
  - Otherwise: tx_shift<=last_rx.
  - bit_cnt<=0.
- ACTIVE behaviour:
  - busy=1, spi_miso_oe=1, spi_miso=tx_shift[WIDTH-1] (MSB first).
  - Synced sclk rising edge: rx_shift<={rx_shift[WIDTH-2:0], mosi_sync}, then bit_cnt++.
  - Synced sclk falling edge: tx_shift shifts left by one, zero-filled. The next bit is valid before the initiator's next rising edge.
  - When a rising edge completes bit WIDTH-1:
    - The next cycle, rx_data and last_rx take the full word and rx_valid pulses.
    - bit_cnt wraps to 0.
    - The following falling edge performs a word load instead of a shift. This gives back-to-back words under one select, with tx_valid/tx_taken handshake per word.
- ACTIVE -> IDLE on the synced ss_n rising edge:
  - If bit_cnt != 0, frame_err pulses, the partial word is discarded, and rx_data/last_rx are unchanged.
  - spi_miso and spi_miso_oe go to 0 in the same cycle.
- Simultaneous events:
  - An ss_n rising edge in the same cycle as a sclk edge: ss_n wins and the sclk edge is ignored.
  - An ss_n falling edge with a sclk edge in the same cycle: the sclk edge is ignored.
- In IDLE, sclk and mosi activity is ignored.
- Reset mid-transfer aborts immediately with no pulses generated. Transfers resume only after a fresh ss_n falling edge.
- Because sclk=0 at select (mode 0), the first bit is presented from the load, not from a falling edge.

Decomposition:
- Shared package spi_pkg holds:
  - the SPI_WIDTH default (8);
  - the state enum {IDLE, ACTIVE};
  - the SYNC_STAGES default.
- One sub-module, sync_ff: a parameterized N-stage single-bit synchronizer with async active-low reset and a reset-value parameter. It is instantiated three times.
- All other logic stays flat in spi_target.

Test Plan:
- Write-then-echo: reset, tx_valid=0. Send 0x12 MSB-first with 100 ns sclk half-periods, then release select. A second select with 8 clocks reads miso = 0x12. Expect rx_valid pulsing once after the 8th rising edge with rx_data=0x12, and no tx_taken.
- Host response: hold tx_valid=1, tx_data=0xA5 at select; initiator sends 0x3C. Expect miso bits 1,0,1,0,0,1,0,1 read, rx_data=0x3C, and tx_taken pulsing exactly once at select.
- Back-to-back: one select with 16 sclk cycles, mosi=0x81 then 0x7E. Expect two rx_valid pulses (0x81, then 0x7E). Second word's miso = 0x81 (echo), loaded at the wrap.
- Aborted frame: 5 sclk cycles, then ss_n high. Expect frame_err=1 for one cycle, rx_data unchanged (prior 0x12), and spi_miso_oe=0 within SYNC_STAGES+2 clk.
- Idle noise: toggle sclk/mosi 20 times with ss_n=1. Expect no rx_valid, busy=0, spi_miso_oe=0.
- Reset mid-transfer: assert rst_n=0 after 3 bits, release, then run a full 0x55 transfer. Expect all outputs 0 during reset, no frame_err, and rx_data=0x55 afterward.
